drum_voice: RTL and testbench



---
 rtl/drum_voice.sv | 160 ++++++++++++++++
 tb/tb_drum_voice.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/drum_voice.sv
// drum_voice: triggered percussion voice mixing a sine table and LFSR noise,
// shaped by a linear decay envelope and emitted once per sample tick.
module drum_voice #(
   parameter int OUT_W      = 8,
   parameter int PHASE_W    = 24,
   parameter int LUT_LOG2   = 5,
   parameter int ENV_W      = 8,
   parameter int SAMPLE_DIV = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               trig,
   input  logic [PHASE_W-1:0] tune,
   input  logic [7:0]         decay,
   input  logic [1:0]         mode,
   output logic [OUT_W-1:0]   sample_out,
   output logic               sample_valid,
   output logic               busy
);

   localparam int  MID   = 1 << (OUT_W - 1);
   localparam int  N     = 1 << LUT_LOG2;
   localparam int  DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int  MIX_W = OUT_W + ENV_W + 2;
   localparam real PI    = 3.14159265358979;

   localparam logic signed [MIX_W-1:0] MID_S   = MIX_W'(MID);
   localparam logic [ENV_W-1:0]        ENV_MAX = {ENV_W{1'b1}};
   localparam logic [DIV_W-1:0]        DIV_TOP = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [15:0]             SEED    = 16'hACE1;

   typedef enum logic {
      IDLE,
      PLAY
   } state_t;

   function automatic logic [OUT_W-1:0] lut_val(input int k);
      real a;
      a = real'(MID) + real'(MID - 1) * $sin(2.0 * PI * real'(k) / real'(N));
      return OUT_W'($rtoi(a + 0.5));
   endfunction

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [ENV_W-1:0]     env_q, env_d;
   logic [7:0]           dcnt_q, dcnt_d;
   logic [OUT_W-1:0]     sample_q, sample_d;
   logic                 valid_q, valid_d;

   logic                 tick;
   logic                 fb;
   logic [LUT_LOG2-1:0]  idx;
   logic [OUT_W-1:0]     lut [N];
   logic [OUT_W-1:0]     tone_u;
   logic [OUT_W-1:0]     noise_u;
   logic signed [MIX_W-1:0] s_tone;
   logic signed [MIX_W-1:0] s_noise;
   logic signed [MIX_W-1:0] s_mix;
   logic signed [MIX_W-1:0] env_s;
   logic signed [MIX_W-1:0] prod;
   logic [OUT_W-1:0]     y;

   // Sine table is a set of elaboration-time constants.
   for (genvar k = 0; k < N; k++) begin : g_lut
      localparam logic [OUT_W-1:0] V = lut_val(k);
      assign lut[k] = V;
   end

   assign tick = (div_cnt_q == DIV_TOP);
   assign idx  = phase_q[PHASE_W-1 -: LUT_LOG2];
   assign fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   always_comb begin
      tone_u  = lut[idx];
      noise_u = lfsr_q[15 -: OUT_W];
      s_tone  = $signed({{(MIX_W - OUT_W){1'b0}}, tone_u}) - MID_S;
      s_noise = $signed({{(MIX_W - OUT_W){1'b0}}, noise_u}) - MID_S;
      env_s   = $signed({{(MIX_W - ENV_W){1'b0}}, env_q});
      s_mix   = s_tone;
      unique case (mode)
         2'd0:    s_mix = s_tone;
         2'd1:    s_mix = s_noise;
         default: s_mix = (s_tone + s_noise) >>> 1;
      endcase
      prod = s_mix * env_s;
      y    = OUT_W'(MID);
      if (state_q == PLAY) begin
         y = OUT_W'(MID_S + (prod >>> ENV_W));
      end
   end

   always_comb begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      lfsr_d    = tick ? {lfsr_q[14:0], fb} : lfsr_q;
      sample_d  = tick ? y : sample_q;
      valid_d   = tick;
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      env_d   = env_q;
      dcnt_d  = dcnt_q;
      if (trig) begin
         // A trigger wins over the tick update on the same edge.
         state_d = PLAY;
         phase_d = '0;
         env_d   = ENV_MAX;
         dcnt_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: state_d = IDLE;
            PLAY: begin
               if (tick) begin
                  phase_d = phase_q + tune;
                  if (dcnt_q == decay) begin
                     dcnt_d = '0;
                     env_d  = env_q - ENV_W'(1);
                     if (env_q == ENV_W'(1)) begin
                        state_d = IDLE;
                     end
                  end else begin
                     dcnt_d = dcnt_q + 8'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         lfsr_q    <= SEED;
         phase_q   <= '0;
         env_q     <= '0;
         dcnt_q    <= '0;
         sample_q  <= OUT_W'(MID);
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         lfsr_q    <= lfsr_d;
         phase_q   <= phase_d;
         env_q     <= env_d;
         dcnt_q    <= dcnt_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign busy         = (state_q == PLAY);

endmodule

// File: tb/tb_drum_voice.sv
// tb_drum_voice: directed and random plays of drum_voice compared sample by
// sample against a closed-form model of phase, envelope and noise sequence.
module tb_drum_voice;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        trig;
   logic [23:0] tune;
   logic [7:0]  decay;
   logic [1:0]  mode;
   logic [7:0]  sample_out;
   logic        sample_valid;
   logic        busy;

   always #5 clk = ~clk;

   drum_voice #(
      .OUT_W(8),
      .PHASE_W(24),
      .LUT_LOG2(5),
      .ENV_W(8),
      .SAMPLE_DIV(DIV)
   ) dut (
      .clk(clk),
      .reset(reset),
      .trig(trig),
      .tune(tune),
      .decay(decay),
      .mode(mode),
      .sample_out(sample_out),
      .sample_valid(sample_valid),
      .busy(busy)
   );

   int          n_chk = 0;
   int          n_err = 0;
   int          gt = 0;
   int          tb_t = 0;
   int          last_wait = 0;
   bit          armed = 1'b0;
   longint      m_tune = 0;
   int          m_decay = 0;
   int          m_mode = 0;
   int          lut_m [32];
   logic [15:0] seq [4096];

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & 16'hB400)};
   endfunction

   // Envelope in force just before global tick g (1-based since reset).
   function automatic int exp_env(input int g);
      int j;
      int e;
      j = g - 1 - tb_t;
      if (!armed || j < 0) return 0;
      e = 255 - j / (m_decay + 1);
      return (e < 0) ? 0 : e;
   endfunction

   function automatic int exp_sample(input int g);
      int     j;
      int     e;
      int     idx;
      int     tn;
      int     nz;
      int     s;
      longint ph;
      e = exp_env(g);
      if (e == 0) return 128;
      j   = g - 1 - tb_t;
      ph  = (longint'(j) * m_tune) % (64'sd1 << 24);
      idx = int'(ph >> 19);
      tn  = lut_m[idx] - 128;
      nz  = int'(seq[g-1][15:8]) - 128;
      if (m_mode == 0) s = tn;
      else if (m_mode == 1) s = nz;
      else s = (tn + nz) >>> 1;
      return 128 + ((s * e) >>> 8);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_sample();
      int c;
      c = 0;
      do begin
         @(posedge clk);
         #1;
         c++;
      end while (!sample_valid && c < 3 * DIV);
      last_wait = c;
      chk("valid_seen", sample_valid, 1);
      if (sample_valid) gt++;
   endtask

   task automatic check_samples(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         wait_sample();
         chk(tag, sample_out, exp_sample(gt));
         chk({tag, "_busy"}, busy, exp_env(gt + 1) > 0);
      end
   endtask

   // Called just after a tick, so the trigger lands on a non-tick edge.
   task automatic start(input int tn, input int dc, input int md);
      tune  = tn[23:0];
      decay = dc[7:0];
      mode  = md[1:0];
      trig  = 1'b1;
      @(posedge clk);
      #1;
      trig    = 1'b0;
      armed   = 1'b1;
      tb_t    = gt;
      m_tune  = longint'(tn & 24'hFFFFFF);
      m_decay = dc;
      m_mode  = md;
      chk("busy_rise", busy, 1);
   endtask

   initial begin
      int fall;
      reset = 1'b1;
      trig  = 1'b0;
      tune  = '0;
      decay = '0;
      mode  = '0;
      seq[0] = 16'hACE1;
      for (int i = 1; i < 4096; i++) seq[i] = lfsr_next(seq[i-1]);
      for (int k = 0; k < 32; k++)
         lut_m[k] = $rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 32.0) + 0.5);

      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_sample", sample_out, 8'h80);
         chk("rst_busy", busy, 0);
         chk("rst_valid", sample_valid, 0);
      end
      reset = 1'b0;
      for (int c = 1; c <= DIV; c++) begin
         @(posedge clk);
         #1;
         chk("first_valid", sample_valid, c == DIV);
      end
      gt = 1;
      chk("idle_sample", sample_out, 8'h80);
      check_samples(2, "idle");
      chk("valid_period", last_wait, DIV);

      start(24'h200000, 255, 0);
      for (int k = 0; k < 260; k++) begin
         wait_sample();
         chk("tone", sample_out, exp_sample(gt));
         chk("tone_busy", busy, 1);
         if (k == 2) chk("tone_idx8", sample_out, 8'hFE);
         if (k == 6) chk("tone_idx24", sample_out, 8'h01);
      end

      start(24'h200000, 0, 0);
      fall = -1;
      for (int k = 1; k <= 258; k++) begin
         wait_sample();
         chk("decay", sample_out, exp_sample(gt));
         chk("decay_busy", busy, exp_env(gt + 1) > 0);
         if (!busy && fall < 0) fall = k;
      end
      chk("busy_fall_tick", fall, 255);
      chk("decay_end", sample_out, 8'h80);

      start(24'h200000, 0, 0);
      check_samples(99, "rt_pre");
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      trig = 1'b1;
      wait_sample();
      trig = 1'b0;
      chk("rt_old_state", sample_out, exp_sample(gt));
      chk("rt_busy", busy, 1);
      tb_t = gt;
      for (int k = 0; k < 10; k++) begin
         wait_sample();
         chk("rt_new", sample_out, exp_sample(gt));
         chk("rt_new_busy", busy, 1);
         if (k == 0) chk("rt_phase0", sample_out, 8'h80);
         if (k == 2) chk("rt_env253", sample_out, 8'hFD);
      end

      start(0, 255, 1);
      check_samples(40, "noise");
      start(0, 255, 0);
      for (int k = 0; k < 8; k++) begin
         wait_sample();
         chk("tone_hold", sample_out, 8'h80);
      end
      start(0, 255, 2);
      check_samples(20, "mix2");
      start(24'h123456, 1, 3);
      check_samples(20, "mix3");

      repeat (5) begin
         start(int'($urandom & 32'hFFFFFF), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
         check_samples(40, "rand");
      end

      start(24'h200000, 0, 2);
      check_samples(50, "pre_rst");
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_sample", sample_out, 8'h80);
      chk("midrst_valid", sample_valid, 0);
      reset = 1'b0;
      armed = 1'b0;
      gt = 0;
      wait_sample();
      chk("post_rst_idle", sample_out, 8'h80);
      start(0, 255, 1);
      check_samples(20, "post_rst_noise");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
